// File: rtl/dht11_pkg.sv
// dht11_pkg: DHT11 state encoding shared with the host reader, default timing in us, checksum helper
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_WAIT_REL,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW
    } dht11_state_t;

    localparam int DHT11_CLK_FREQ_HZ  = 50_000_000;
    localparam int DHT11_START_MIN_US = 18000;
    localparam int DHT11_RESP_WAIT_US = 13;
    localparam int DHT11_RESP_LOW_US  = 83;
    localparam int DHT11_RESP_HIGH_US = 87;
    localparam int DHT11_BIT_LOW_US   = 50;
    localparam int DHT11_BIT0_HIGH_US = 26;
    localparam int DHT11_BIT1_HIGH_US = 70;

    function automatic logic [7:0] dht11_csum(input logic [31:0] d);
        return d[31:24] + d[23:16] + d[15:8] + d[7:0];
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick: one-cycle tick every CLK_FREQ_HZ/1e6 clocks; rst restarts the period
module dht11_us_tick import dht11_pkg::*; #(
    parameter int CLK_FREQ_HZ = DHT11_CLK_FREQ_HZ
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int W   = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(DIV - 1);

    always_ff @(posedge clk) begin
        if (rst || tick) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator; answers a host start pulse with response, 40 data bits and end pulse.
// Define DHT11_CRC_INJECT_EN to add crc_inject, which inverts the transmitted checksum byte.
module dht11_responder import dht11_pkg::*; #(
    parameter int CLK_FREQ_HZ  = DHT11_CLK_FREQ_HZ,
    parameter int START_MIN_US = DHT11_START_MIN_US,
    parameter int RESP_WAIT_US = DHT11_RESP_WAIT_US,
    parameter int RESP_LOW_US  = DHT11_RESP_LOW_US,
    parameter int RESP_HIGH_US = DHT11_RESP_HIGH_US,
    parameter int BIT_LOW_US   = DHT11_BIT_LOW_US,
    parameter int BIT0_HIGH_US = DHT11_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US = DHT11_BIT1_HIGH_US
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dht_i,
`ifdef DHT11_CRC_INJECT_EN
    input  logic        crc_inject,
`endif
    input  logic [31:0] meas_data,
    output logic        dht_oe,
    output logic        busy,
    output logic        frame_done,
    output logic        start_err
);
    localparam logic [15:0] T_START = 16'(START_MIN_US);
    localparam logic [15:0] T_WAIT  = 16'(RESP_WAIT_US);
    localparam logic [15:0] T_RL    = 16'(RESP_LOW_US);
    localparam logic [15:0] T_RH    = 16'(RESP_HIGH_US);
    localparam logic [15:0] T_BL    = 16'(BIT_LOW_US);
    localparam logic [15:0] T_B0    = 16'(BIT0_HIGH_US);
    localparam logic [15:0] T_B1    = 16'(BIT1_HIGH_US);

    dht11_state_t state, state_next;
    logic        s1, s2, s_d, fall, rise, tick, phase_chg;
    logic [15:0] us;
    logic [5:0]  bit_idx;
    logic [39:0] frame;
    logic [7:0]  csum_tx;

    assign fall      = s_d & ~s2;
    assign rise      = ~s_d & s2;
    assign phase_chg = state_next != state;

`ifdef DHT11_CRC_INJECT_EN
    assign csum_tx = dht11_csum(meas_data) ^ {8{crc_inject}};
`else
    assign csum_tx = dht11_csum(meas_data);
`endif

    // the divider restarts with each phase so a phase lasts N us plus one cycle
    dht11_us_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk  (clk),
        .rst  (rst || phase_chg),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (fall) state_next = ST_START_LOW;
            ST_START_LOW: if (rise) state_next = us >= T_START ? ST_WAIT_REL : ST_IDLE;
            ST_WAIT_REL:  if (us == T_WAIT) state_next = ST_RESP_LOW;
            ST_RESP_LOW:  if (us == T_RL) state_next = ST_RESP_HIGH;
            ST_RESP_HIGH: if (us == T_RH) state_next = ST_BIT_LOW;
            ST_BIT_LOW:   if (us == T_BL) state_next = ST_BIT_HIGH;
            ST_BIT_HIGH:  if (us == (frame[bit_idx] ? T_B1 : T_B0))
                              state_next = bit_idx == 6'd0 ? ST_END_LOW : ST_BIT_LOW;
            ST_END_LOW:   if (us == T_BL) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dht_oe = state == ST_RESP_LOW || state == ST_BIT_LOW || state == ST_END_LOW;
        busy   = state != ST_IDLE && state != ST_START_LOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, s2, s_d} <= 3'b111;
            us            <= '0;
            bit_idx       <= '0;
            frame         <= '0;
            frame_done    <= 1'b0;
            start_err     <= 1'b0;
        end else begin
            s1         <= dht_i;
            s2         <= s1;
            s_d        <= s2;
            us         <= phase_chg ? '0 : (tick && us != '1) ? us + 1'b1 : us;
            frame_done <= state == ST_END_LOW && state_next == ST_IDLE;
            start_err  <= state == ST_START_LOW && state_next == ST_IDLE;
            if (state == ST_START_LOW && state_next == ST_WAIT_REL) frame <= {meas_data, csum_tx};
            if (state_next == ST_BIT_LOW && state != ST_BIT_LOW)
                bit_idx <= state == ST_RESP_HIGH ? 6'd39 : bit_idx - 1'b1;
        end
    end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: bench host drives start pulses, decodes the responder frame by pulse width
module tb_dht11_responder;
    localparam int CLK_HZ   = 2_000_000;
    localparam int START_US = 200;
    localparam int CPU      = CLK_HZ / 1_000_000;
    localparam int LIM      = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_low = 1'b0;
    logic [31:0] meas_data = '0;
    logic        dht_i, dht_oe, busy, frame_done, start_err;
`ifdef DHT11_CRC_INJECT_EN
    logic        crc_inject = 1'b0;
`endif
    int total = 0, bad = 0, fd_cnt = 0, se_cnt = 0;

    assign dht_i = ~(host_low | dht_oe);

    dht11_responder #(.CLK_FREQ_HZ(CLK_HZ), .START_MIN_US(START_US)) dut (
        .clk        (clk),
        .rst        (rst),
        .dht_i      (dht_i),
`ifdef DHT11_CRC_INJECT_EN
        .crc_inject (crc_inject),
`endif
        .meas_data  (meas_data),
        .dht_oe     (dht_oe),
        .busy       (busy),
        .frame_done (frame_done),
        .start_err  (start_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (start_err) se_cnt++;
    end

    function automatic logic [39:0] model(input logic [31:0] m, input logic inv);
        int s;
        logic [7:0] c;
        s = int'(m[31:24]) + int'(m[23:16]) + int'(m[15:8]) + int'(m[7:0]);
        c = 8'(s % 256);
        return {m, inv ? ~c : c};
    endfunction

    function automatic logic host_csum_ok(input logic [39:0] b);
        int s;
        s = int'(b[39:32]) + int'(b[31:24]) + int'(b[23:16]) + int'(b[15:8]);
        return int'(b[7:0]) == s % 256;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic in_range(input string tag, input int v, input int lo, input int hi);
        total++;
        assert ((v >= lo && v <= hi) === 1'b1) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
        end
    endtask

    task automatic host_start(input int low_us);
        @(negedge clk);
        host_low = 1'b1;
        repeat (low_us * CPU) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic wait_oe(input logic lvl, output int n);
        n = 0;
        while (dht_oe !== lvl && n < LIM) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (dht_oe === lvl && n < LIM) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input string tag, input int low_us, input logic [31:0] mid,
                             input logic [39:0] exp, output logic [39:0] bits);
        int fd0, tw, trl, trh, tend, l, h, hu, blb, bhb;
        fd0 = fd_cnt;
        blb = 0;
        bhb = 0;
        host_start(low_us);
        wait_oe(1'b1, tw);
        measure(1'b1, trl);
        meas_data = mid;
        measure(1'b0, trh);
        for (int i = 39; i >= 0; i--) begin
            measure(1'b1, l);
            measure(1'b0, h);
            bits[i] = h > 48 * CPU;
            hu = bits[i] ? 70 : 26;
            if (l < 50 * CPU || l > 50 * CPU + 2) blb++;
            if (h < hu * CPU || h > hu * CPU + 2) bhb++;
        end
        measure(1'b1, tend);
        @(negedge clk);
        in_range({tag, "_wait"}, tw, 13 * CPU, 13 * CPU + 5);
        in_range({tag, "_resp_low"}, trl, 83 * CPU, 83 * CPU + 2);
        in_range({tag, "_resp_high"}, trh, 87 * CPU, 87 * CPU + 2);
        check({tag, "_bit_low_bad"}, 64'(blb), 64'd0);
        check({tag, "_bit_high_bad"}, 64'(bhb), 64'd0);
        in_range({tag, "_end_low"}, tend, 50 * CPU, 50 * CPU + 2);
        check({tag, "_data"}, 64'(bits), 64'(exp));
        check({tag, "_done"}, 64'(fd_cnt - fd0), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic short_start(input string tag, input int low_us);
        int se0, act;
        se0 = se_cnt;
        act = 0;
        host_start(low_us);
        repeat (300) begin
            @(negedge clk);
            if (dht_oe || busy) act++;
        end
        check({tag, "_err"}, 64'(se_cnt - se0), 64'd1);
        check({tag, "_quiet"}, 64'(act), 64'd0);
    endtask

    initial begin
        logic [39:0] bits;
        logic [31:0] m;
        logic prev;
        int n, k, fd0;
        repeat (3) @(negedge clk);
        check("rst_oe", 64'(dht_oe), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_err", 64'(start_err), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        meas_data = 32'h3700_1A05;
        run_frame("t1", 250, 32'h3700_1A05, model(32'h3700_1A05, 1'b0), bits);
        check("t1_csum", 64'(bits[7:0]), 64'h56);
        check("t1_host_ok", 64'(host_csum_ok(bits)), 64'd1);

        short_start("t2_short", 50);
        short_start("t2_edge", 195);

        meas_data = 32'hFF01_0000;
        run_frame("t4", 230, 32'h1234_5678, model(32'hFF01_0000, 1'b0), bits);
        check("t4_csum", 64'(bits[7:0]), 64'h00);

        meas_data = $urandom;
        fd0 = fd_cnt;
        host_start(220);
        n = 0;
        k = 0;
        prev = 1'b0;
        while (k < 21 && n < 20000) begin
            @(negedge clk);
            n++;
            if (dht_oe && !prev) k++;
            prev = dht_oe;
        end
        check("t5_reach_bit20", 64'(k), 64'd21);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_oe", 64'(dht_oe), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("t5_no_done", 64'(fd_cnt - fd0), 64'd0);
        m = $urandom;
        meas_data = m;
        run_frame("t5_after", 240, m, model(m, 1'b0), bits);

        for (int r = 0; r < 2; r++) begin
            m = $urandom;
            meas_data = m;
            run_frame($sformatf("rnd%0d", r), int'($urandom_range(205, 260)), $urandom, model(m, 1'b0), bits);
            check($sformatf("rnd%0d_host_ok", r), 64'(host_csum_ok(bits)), 64'd1);
        end

`ifdef DHT11_CRC_INJECT_EN
        meas_data = 32'h3700_1A05;
        crc_inject = 1'b1;
        run_frame("t6", 250, 32'h3700_1A05, model(32'h3700_1A05, 1'b1), bits);
        crc_inject = 1'b0;
        check("t6_csum", 64'(bits[7:0]), 64'hA9);
        check("t6_host_ok", 64'(host_csum_ok(bits)), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
